// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback arbiter: source ids, buffered entry
// layout and the round-robin winner search.
package wb_pkg;

  localparam int SRC_MEM = 0;
  localparam int SRC_CSR = 1;
  localparam int SRC_MUL = 2;
  localparam int SRC_DIV = 3;
  localparam int SRC_ALU = 4;

  localparam int WB_XLEN = 32;
  localparam int WB_RW   = 5;
  localparam int RR_MAX  = 32;

  typedef struct packed {
    logic [WB_RW-1:0]   rd;
    logic [WB_XLEN-1:0] res;
    logic               fpu;
  } wb_entry_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_pick_t;

  // First set bit of nonempty at or after ptr, wrapping modulo n (n <= RR_MAX).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] nonempty,
                                       input int ptr, input int n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = 0; k < RR_MAX; k++) begin
      if (k < n && !r.found) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (nonempty[j[4:0]]) begin
          r.found = 1'b1;
          r.idx   = j[4:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source circular buffer with a registered occupancy count.
// full/empty come from registered state only; flush discards everything, including a same-cycle push.
module wb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int RW    = 5
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [RW+XLEN:0] din,
  output logic [RW+XLEN:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [RW+XLEN:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (Rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/writeback_arb.sv
// Round-robin arbiter from NSRC buffered producers onto one registered register-file
// write port, plus the WB->ID forwarding register. Push-to-wb latency is 2 cycles.
module writeback_arb
  import wb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NSRC  = 5,
  parameter int DEPTH = 2,
  parameter int RW    = 5
) (
  input  logic                    clk,
  input  logic                    Rst,
  input  logic                    hold,
  input  logic                    flush,
  input  logic [NSRC-1:0]         src_valid,
  output logic [NSRC-1:0]         src_ready,
  input  logic [NSRC*RW-1:0]      src_rd,
  input  logic [NSRC*XLEN-1:0]    src_res,
  input  logic [NSRC-1:0]         src_fpu,
  output logic                    wb_valid,
  output logic [RW-1:0]           wb_rd,
  output logic [XLEN-1:0]         wb_res,
  output logic                    wb_fpusrc,
  output logic [$clog2(NSRC)-1:0] wb_src,
  output logic [RW-1:0]           fwd_rd,
  output logic [XLEN-1:0]         fwd_res,
  output logic                    fwd_regwrite,
  output logic                    fwd_fpusrc,
  output logic                    busy
);

  localparam int SW = $clog2(NSRC);
  localparam int EW = RW + XLEN + 1;

  logic [NSRC-1:0] push, pop, full, empty;
  logic [EW-1:0]   head [NSRC];
  logic [EW-1:0]   win;
  rr_pick_t        pick;
  logic [SW-1:0]   pick_idx;

  logic [SW-1:0]   rr_q;
  logic            wb_valid_q, wb_fpu_q, fwd_rw_q, fwd_fpu_q;
  logic [RW-1:0]   wb_rd_q, fwd_rd_q;
  logic [XLEN-1:0] wb_res_q, fwd_res_q;
  logic [SW-1:0]   wb_src_q;

  assign pick     = rr_pick(RR_MAX'(~empty), 32'(rr_q), NSRC);
  assign pick_idx = pick.idx[SW-1:0];

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    assign push[g]      = src_valid[g] && !full[g];
    assign pop[g]       = pick.found && !hold && !flush && (pick_idx == SW'(g));
    assign src_ready[g] = !full[g];

    wb_src_fifo #(.DEPTH(DEPTH), .XLEN(XLEN), .RW(RW)) u_fifo (
      .clk   (clk),
      .Rst   (Rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .flush (flush),
      .din   ({src_rd[g*RW +: RW], src_res[g*XLEN +: XLEN], src_fpu[g]}),
      .dout  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pick_idx == SW'(i)) win = head[i];
    end
  end

  // Integer x0 entries still drain their FIFO but never assert the write enable.
  always_ff @(posedge clk) begin
    if (Rst) begin
      rr_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_res_q   <= '0;
      wb_fpu_q   <= 1'b0;
      wb_src_q   <= '0;
      fwd_rd_q   <= '0;
      fwd_res_q  <= '0;
      fwd_rw_q   <= 1'b0;
      fwd_fpu_q  <= 1'b0;
    end else if (!hold) begin
      fwd_rd_q  <= wb_rd_q;
      fwd_res_q <= wb_res_q;
      fwd_rw_q  <= wb_valid_q;
      fwd_fpu_q <= wb_fpu_q;
      if (pick.found && !flush) begin
        wb_valid_q <= !((win[EW-1 -: RW] == '0) && !win[0]);
        wb_rd_q    <= win[EW-1 -: RW];
        wb_res_q   <= win[XLEN:1];
        wb_fpu_q   <= win[0];
        wb_src_q   <= pick_idx;
        rr_q       <= (pick_idx == SW'(NSRC-1)) ? '0 : pick_idx + 1'b1;
      end else begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_res       = wb_res_q;
  assign wb_fpusrc    = wb_fpu_q;
  assign wb_src       = wb_src_q;
  assign fwd_rd       = fwd_rd_q;
  assign fwd_res      = fwd_res_q;
  assign fwd_regwrite = fwd_rw_q;
  assign fwd_fpusrc   = fwd_fpu_q;
  assign busy         = |(~empty);

endmodule

// File: tb/tb_writeback_arb.sv
// Bench for writeback_arb: directed vector table, hand-written corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_writeback_arb;
  import wb_pkg::*;

  localparam int NSRC = 5, RW = 5, XLEN = 32, DEPTH = 2;

  logic clk = 1'b0;
  logic Rst, hold, flush;
  logic [NSRC-1:0] src_valid, src_ready, src_fpu;
  logic [NSRC*RW-1:0] src_rd;
  logic [NSRC*XLEN-1:0] src_res;
  logic wb_valid, wb_fpusrc, fwd_regwrite, fwd_fpusrc, busy;
  logic [RW-1:0] wb_rd, fwd_rd;
  logic [XLEN-1:0] wb_res, fwd_res;
  logic [2:0] wb_src;

  logic [RW-1:0] t_rd [NSRC];
  logic [XLEN-1:0] t_res [NSRC];

  int checks = 0;
  int errors = 0;

  writeback_arb #(.XLEN(XLEN), .NSRC(NSRC), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk(clk), .Rst(Rst), .hold(hold), .flush(flush),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd),
    .src_res(src_res), .src_fpu(src_fpu),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_res(wb_res), .wb_fpusrc(wb_fpusrc),
    .wb_src(wb_src), .fwd_rd(fwd_rd), .fwd_res(fwd_res),
    .fwd_regwrite(fwd_regwrite), .fwd_fpusrc(fwd_fpusrc), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      src_rd[i*RW +: RW]     = t_rd[i];
      src_res[i*XLEN +: XLEN] = t_res[i];
    end
  end

  // Reference model: one queue per source plus the architectural output registers.
  wb_entry_t q [NSRC][$];
  int m_rr = 0;
  logic m_wb_valid = 0, m_wb_fpu = 0, m_fwd_rw = 0, m_fwd_fpu = 0;
  logic [RW-1:0] m_wb_rd = 0, m_fwd_rd = 0;
  logic [XLEN-1:0] m_wb_res = 0, m_fwd_res = 0;
  int m_wb_src = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [NSRC-1:0] rdy;
    int win;
    wb_entry_t e;
    if (Rst) begin
      for (int i = 0; i < NSRC; i++) q[i].delete();
      m_rr = 0; m_wb_valid = 0; m_wb_rd = 0; m_wb_res = 0; m_wb_fpu = 0; m_wb_src = 0;
      m_fwd_rd = 0; m_fwd_res = 0; m_fwd_rw = 0; m_fwd_fpu = 0;
      return;
    end
    for (int i = 0; i < NSRC; i++) rdy[i] = (q[i].size() < DEPTH);
    win = -1;
    if (!hold && !flush)
      for (int k = 0; k < NSRC; k++)
        if (win < 0 && q[(m_rr + k) % NSRC].size() > 0) win = (m_rr + k) % NSRC;
    if (!hold) begin
      m_fwd_rd = m_wb_rd; m_fwd_res = m_wb_res; m_fwd_rw = m_wb_valid; m_fwd_fpu = m_wb_fpu;
      if (win >= 0) begin
        e = q[win].pop_front();
        m_wb_valid = !(e.rd == 0 && !e.fpu);
        m_wb_rd = e.rd; m_wb_res = e.res; m_wb_fpu = e.fpu; m_wb_src = win;
        m_rr = (win + 1) % NSRC;
      end else m_wb_valid = 0;
    end
    for (int i = 0; i < NSRC; i++)
      if (src_valid[i] && rdy[i]) begin
        e.rd = t_rd[i]; e.res = t_res[i]; e.fpu = src_fpu[i];
        q[i].push_back(e);
      end
    if (flush) for (int i = 0; i < NSRC; i++) q[i].delete();
  endtask

  task automatic cyc();
    logic any;
    for (int i = 0; i < NSRC; i++) chk($sformatf("ready%0d", i), 64'(src_ready[i]), 64'(q[i].size() < DEPTH));
    model_step();
    @(posedge clk); #1;
    any = 0;
    for (int i = 0; i < NSRC; i++) if (q[i].size() > 0) any = 1;
    chk("wb_valid", 64'(wb_valid), 64'(m_wb_valid));
    chk("wb_rd", 64'(wb_rd), 64'(m_wb_rd));
    chk("wb_res", 64'(wb_res), 64'(m_wb_res));
    chk("wb_fpusrc", 64'(wb_fpusrc), 64'(m_wb_fpu));
    chk("wb_src", 64'(wb_src), 64'(m_wb_src));
    chk("fwd_rd", 64'(fwd_rd), 64'(m_fwd_rd));
    chk("fwd_res", 64'(fwd_res), 64'(m_fwd_res));
    chk("fwd_regwrite", 64'(fwd_regwrite), 64'(m_fwd_rw));
    chk("fwd_fpusrc", 64'(fwd_fpusrc), 64'(m_fwd_fpu));
    chk("busy", 64'(busy), 64'(any));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wb_valid"}, 64'(wb_valid), 0);
    chk({tag, "_wb_rd"}, 64'(wb_rd), 0);
    chk({tag, "_wb_res"}, 64'(wb_res), 0);
    chk({tag, "_wb_fpusrc"}, 64'(wb_fpusrc), 0);
    chk({tag, "_wb_src"}, 64'(wb_src), 0);
    chk({tag, "_fwd_rd"}, 64'(fwd_rd), 0);
    chk({tag, "_fwd_res"}, 64'(fwd_res), 0);
    chk({tag, "_fwd_rw"}, 64'(fwd_regwrite), 0);
    chk({tag, "_fwd_fpu"}, 64'(fwd_fpusrc), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
  endtask

  typedef struct {
    logic [NSRC-1:0] vld;
    logic            exp_valid;
    int              exp_src;
    logic            exp_busy;
  } vec_t;
  vec_t vt [8];

  initial begin
    logic [XLEN-1:0] s_wb_res, s_fwd_res;
    logic s_wb_valid, s_fwd_rw;
    int n;

    Rst = 1; hold = 0; flush = 0; src_valid = '0; src_fpu = '0;
    for (int i = 0; i < NSRC; i++) begin t_rd[i] = RW'(i + 1); t_res[i] = 32'h100 + i; end
    t_rd[SRC_ALU] = 7; t_res[SRC_ALU] = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    model_step();
    chk_all_zero("reset");
    chk("reset_ready", 64'(src_ready), 64'(5'b11111));
    Rst = 0;

    // Single ALU result, then a three-way collision starting from rr_ptr = 0.
    vt[0] = '{5'b10000, 1'b0, 0, 1'b1};
    vt[1] = '{5'b00000, 1'b1, 4, 1'b0};
    vt[2] = '{5'b00000, 1'b0, 4, 1'b0};
    vt[3] = '{5'b10101, 1'b0, 4, 1'b1};
    vt[4] = '{5'b00000, 1'b1, 0, 1'b1};
    vt[5] = '{5'b00000, 1'b1, 2, 1'b1};
    vt[6] = '{5'b00000, 1'b1, 4, 1'b0};
    vt[7] = '{5'b00000, 1'b0, 4, 1'b0};
    for (int r = 0; r < 8; r++) begin
      src_valid = vt[r].vld;
      cyc();
      chk($sformatf("vec%0d_valid", r), 64'(wb_valid), 64'(vt[r].exp_valid));
      chk($sformatf("vec%0d_src", r), 64'(wb_src), 64'(vt[r].exp_src));
      chk($sformatf("vec%0d_busy", r), 64'(busy), 64'(vt[r].exp_busy));
      if (r == 1) begin
        chk("alu_rd", 64'(wb_rd), 64'd7);
        chk("alu_res", 64'(wb_res), 64'hDEADBEEF);
      end
      if (r == 2) begin
        chk("alu_fwd_rd", 64'(fwd_rd), 64'd7);
        chk("alu_fwd_res", 64'(fwd_res), 64'hDEADBEEF);
        chk("alu_fwd_rw", 64'(fwd_regwrite), 64'd1);
      end
    end

    // Backpressure on source 3 while frozen.
    s_wb_res = wb_res; s_fwd_res = fwd_res; s_wb_valid = wb_valid; s_fwd_rw = fwd_regwrite;
    hold = 1; src_valid = 5'b01000; t_rd[3] = 9;
    for (int k = 0; k < 3; k++) begin
      t_res[3] = 32'h300 + k;
      chk($sformatf("bp_ready%0d", k), 64'(src_ready[3]), 64'(k < 2));
      cyc();
      chk("bp_wb_frozen", 64'(wb_res), 64'(s_wb_res));
      chk("bp_fwd_frozen", 64'(fwd_res), 64'(s_fwd_res));
      chk("bp_valid_frozen", 64'(wb_valid), 64'(s_wb_valid));
      chk("bp_rw_frozen", 64'(fwd_regwrite), 64'(s_fwd_rw));
    end
    hold = 0; src_valid = '0;
    cyc(); chk("bp_first_src", 64'(wb_src), 64'd3); chk("bp_first_res", 64'(wb_res), 64'h300);
    cyc(); chk("bp_second_res", 64'(wb_res), 64'h301); chk("bp_second_valid", 64'(wb_valid), 64'd1);
    cyc(); chk("bp_no_third", 64'(wb_valid), 64'd0);

    // x0 suppression, then the same entry as an FP f0 write.
    for (int f = 0; f < 2; f++) begin
      t_rd[1] = 0; t_res[1] = 32'h1234; src_fpu[1] = 1'(f); src_valid = 5'b00010;
      cyc();
      src_valid = '0;
      cyc();
      chk($sformatf("x0_valid_fpu%0d", f), 64'(wb_valid), 64'(f));
      chk($sformatf("x0_drained_fpu%0d", f), 64'(busy), 64'd0);
      cyc();
      chk($sformatf("x0_fwd_rw_fpu%0d", f), 64'(fwd_regwrite), 64'(f));
    end
    src_fpu = '0; t_rd[1] = 2;

    // Flush with a same-cycle push.
    hold = 1; src_valid = 5'b00111;
    cyc();
    hold = 0; flush = 1; src_valid = 5'b01000;
    cyc();
    chk("flush_busy", 64'(busy), 64'd0);
    flush = 0; src_valid = '0;
    for (int k = 0; k < 4; k++) begin cyc(); chk("flush_no_wb", 64'(wb_valid), 64'd0); end

    // Move rr_ptr off zero, fill, then reset mid-operation.
    src_valid = 5'b00010; cyc(); src_valid = '0; cyc();
    hold = 1; src_valid = 5'b00111; cyc();
    Rst = 1; cyc();
    chk_all_zero("midrst");
    Rst = 0; hold = 0; src_valid = 5'b10001; cyc();
    src_valid = '0;
    cyc(); chk("rst_rr_first", 64'(wb_src), 64'd0); chk("rst_rr_valid", 64'(wb_valid), 64'd1);
    cyc(); chk("rst_rr_second", 64'(wb_src), 64'd4);
    cyc();

    // Fairness between two always-valid sources.
    t_rd[1] = 2; t_rd[3] = 4; src_valid = 5'b01010; n = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (wb_valid) begin
        chk("rr_fair", 64'(wb_src), (n % 2 == 0) ? 64'd1 : 64'd3);
        n++;
      end
    end
    chk("rr_fair_count", 64'(n), 64'd9);
    src_valid = '0;
    repeat (6) cyc();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      src_valid = NSRC'($urandom);
      src_fpu = NSRC'($urandom);
      for (int i = 0; i < NSRC; i++) begin
        t_rd[i] = RW'($urandom_range(0, 3));
        t_res[i] = $urandom;
      end
      hold = ($urandom % 4 == 0);
      flush = !hold && ($urandom % 32 == 0);
      Rst = ($urandom % 64 == 0);
      cyc();
    end
    Rst = 0; hold = 0; flush = 0; src_valid = '0;
    repeat (8) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
